// File: rtl/vga_frame_monitor.sv
// ---------------------------------------------------------------------------
// vga_frame_monitor
//   Receive side of the VGA pixel interface. It turns HS/VS/BLANK/RGB back
//   into pixel coordinates and per-frame statistics: active width/height,
//   line total, RGB checksum, frame count, lock status and a sticky line
//   width error flag.
//
// Ports
//   clk_clk      : system clock; all VGA inputs are synchronous to it
//   reset_reset  : synchronous, active-high reset
//   pix_en       : pixel strobe; inputs are sampled only when high
//   vga_HS/VS    : horizontal / vertical sync, active low
//   vga_BLANK    : 1 = visible pixel
//   vga_R/G/B    : pixel colour, 8 bits each
//   pix_valid    : registered active pixel strobe
//   pix_x/pix_y  : column / row of the pixel flagged by pix_valid
//   pix_rgb      : {R,G,B} of the pixel flagged by pix_valid
//   frame_done   : one-clock pulse at each tracked frame boundary
//   meas_width   : active pixels on the last active line of the previous frame
//   meas_height  : active lines in the previous frame
//   meas_htotal  : pix_en samples between the last two HS falling edges
//   frame_cksum  : sum of R+G+B over the previous frame, mod 2^24
//   frame_cnt    : completed frames, wrapping
//   locked       : last frame matched EXP_H_ACTIVE x EXP_V_ACTIVE
//   line_err     : sticky, some active line width differed from EXP_H_ACTIVE
// ---------------------------------------------------------------------------
module vga_frame_monitor #(
  parameter int unsigned EXP_H_ACTIVE = 640,
  parameter int unsigned EXP_V_ACTIVE = 480,
  parameter int unsigned CNT_W        = 12
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             pix_en,
  input  logic             vga_HS,
  input  logic             vga_VS,
  input  logic             vga_BLANK,
  input  logic [7:0]       vga_R,
  input  logic [7:0]       vga_G,
  input  logic [7:0]       vga_B,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [23:0]      pix_rgb,
  output logic             frame_done,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_height,
  output logic [CNT_W-1:0] meas_htotal,
  output logic [23:0]      frame_cksum,
  output logic [15:0]      frame_cnt,
  output logic             locked,
  output logic             line_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXP_W    = CNT_W'(EXP_H_ACTIVE);
  localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_V_ACTIVE);

  typedef enum logic [1:0] {
    ST_SEEK    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_e           state_q, state_d;
  logic             hs_prev_q, hs_prev_d;
  logic             vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic [CNT_W-1:0] htot_q, htot_d;
  logic [CNT_W-1:0] last_w_q, last_w_d;
  logic [23:0]      acc_q, acc_d;
  logic             pix_valid_q, pix_valid_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic [23:0]      pix_rgb_q, pix_rgb_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] meas_width_q, meas_width_d;
  logic [CNT_W-1:0] meas_height_q, meas_height_d;
  logic [CNT_W-1:0] meas_htotal_q, meas_htotal_d;
  logic [23:0]      cksum_q, cksum_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             locked_q, locked_d;
  logic             line_err_q, line_err_d;

  logic             hs_fall_s, vs_fall_s, tracking_s, active_s;
  logic             line_close_s, frame_close_s, frame_match_s;
  logic [CNT_W-1:0] y_line_s, w_line_s, x_base_s, y_base_s;
  logic [23:0]      acc_base_s;
  logic [9:0]       rgb_sum_s;

  // Edge detection, line/frame closing and all datapath next-state values.
  always_comb begin
    hs_fall_s     = hs_prev_q & ~vga_HS;
    vs_fall_s     = vs_prev_q & ~vga_VS;
    tracking_s    = (state_q != ST_SEEK);
    active_s      = tracking_s & vga_BLANK;
    frame_close_s = vs_fall_s & tracking_s;
    // Only a line that carried active pixels advances the row count.
    line_close_s  = hs_fall_s & (x_q != CNT_ZERO);
    // Line is closed before the frame, so the frame latch sees that line.
    y_line_s      = line_close_s ? sat_inc(y_q) : y_q;
    w_line_s      = line_close_s ? x_q : last_w_q;
    // A pixel sampled together with an edge belongs to the new line/frame.
    x_base_s      = hs_fall_s ? CNT_ZERO : x_q;
    y_base_s      = frame_close_s ? CNT_ZERO : y_line_s;
    acc_base_s    = frame_close_s ? 24'h00_0000 : acc_q;
    frame_match_s = (w_line_s == EXP_W) && (y_line_s == EXP_H);
    rgb_sum_s     = {2'b00, vga_R} + {2'b00, vga_G} + {2'b00, vga_B};

    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    x_d           = x_q;
    y_d           = y_q;
    htot_d        = htot_q;
    last_w_d      = last_w_q;
    acc_d         = acc_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_rgb_d     = pix_rgb_q;
    frame_done_d  = 1'b0;
    meas_width_d  = meas_width_q;
    meas_height_d = meas_height_q;
    meas_htotal_d = meas_htotal_q;
    cksum_d       = cksum_q;
    frame_cnt_d   = frame_cnt_q;
    line_err_d    = line_err_q;

    if (pix_en) begin
      hs_prev_d     = vga_HS;
      vs_prev_d     = vga_VS;
      // The falling-edge sample is the first sample of the new line.
      htot_d        = hs_fall_s ? CNT_ONE : sat_inc(htot_q);
      meas_htotal_d = hs_fall_s ? htot_q : meas_htotal_q;
      line_err_d    = line_err_q | (line_close_s & (x_q != EXP_W));
      x_d           = active_s ? sat_inc(x_base_s) : x_base_s;
      y_d           = y_base_s;
      last_w_d      = frame_close_s ? CNT_ZERO : w_line_s;
      acc_d         = active_s ? (acc_base_s + {14'd0, rgb_sum_s}) : acc_base_s;
      pix_valid_d   = active_s;
      pix_x_d       = active_s ? x_base_s : pix_x_q;
      pix_y_d       = active_s ? y_base_s : pix_y_q;
      pix_rgb_d     = active_s ? {vga_R, vga_G, vga_B} : pix_rgb_q;
      frame_done_d  = frame_close_s;
      meas_width_d  = frame_close_s ? w_line_s : meas_width_q;
      meas_height_d = frame_close_s ? y_line_s : meas_height_q;
      cksum_d       = frame_close_s ? acc_q : cksum_q;
      frame_cnt_d   = frame_close_s ? (frame_cnt_q + 16'd1) : frame_cnt_q;
    end else begin
      pix_valid_d   = 1'b0;
      frame_done_d  = 1'b0;
    end
  end

  // Lock FSM: advances only on a sampled VS falling edge.
  always_comb begin
    state_d = state_q;
    if (pix_en && vs_fall_s) begin
      case (state_q)
        ST_SEEK:    state_d = ST_MEASURE;
        ST_MEASURE: state_d = frame_match_s ? ST_LOCKED : ST_MEASURE;
        ST_LOCKED:  state_d = frame_match_s ? ST_LOCKED : ST_MEASURE;
        default:    state_d = ST_SEEK;
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q       <= ST_SEEK;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      x_q           <= CNT_ZERO;
      y_q           <= CNT_ZERO;
      htot_q        <= CNT_ZERO;
      last_w_q      <= CNT_ZERO;
      acc_q         <= 24'h00_0000;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= CNT_ZERO;
      pix_y_q       <= CNT_ZERO;
      pix_rgb_q     <= 24'h00_0000;
      frame_done_q  <= 1'b0;
      meas_width_q  <= CNT_ZERO;
      meas_height_q <= CNT_ZERO;
      meas_htotal_q <= CNT_ZERO;
      cksum_q       <= 24'h00_0000;
      frame_cnt_q   <= 16'h0000;
      locked_q      <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      x_q           <= x_d;
      y_q           <= y_d;
      htot_q        <= htot_d;
      last_w_q      <= last_w_d;
      acc_q         <= acc_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      frame_done_q  <= frame_done_d;
      meas_width_q  <= meas_width_d;
      meas_height_q <= meas_height_d;
      meas_htotal_q <= meas_htotal_d;
      cksum_q       <= cksum_d;
      frame_cnt_q   <= frame_cnt_d;
      locked_q      <= locked_d;
      line_err_q    <= line_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_done  = frame_done_q;
  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;
  assign meas_htotal = meas_htotal_q;
  assign frame_cksum = cksum_q;
  assign frame_cnt   = frame_cnt_q;
  assign locked      = locked_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_monitor
//   Drives whole VGA frames (scaled down to 16x8 active inside 24x12 total)
//   with random colours and random pix_en gaps. Expected outputs are derived
//   from the frame description: pixel coordinates from the raster position,
//   frame statistics from the list of active lines, lock/line error from the
//   frame shape.
// ---------------------------------------------------------------------------
module tb_vga_frame_monitor;

  localparam int EXP_H = 16;
  localparam int EXP_V = 8;
  localparam int CNT_W = 12;
  localparam int HTOT  = 24;
  localparam int HSYNC = 3;
  localparam int VTOT  = 12;
  localparam int VSYNC = 2;
  localparam int CMAX  = 4095;

  logic             clk_clk = 1'b0;
  logic             reset_reset = 1'b0;
  logic             pix_en = 1'b0;
  logic             vga_HS = 1'b1, vga_VS = 1'b1, vga_BLANK = 1'b0;
  logic [7:0]       vga_R = 8'd0, vga_G = 8'd0, vga_B = 8'd0;
  logic             pix_valid, frame_done, locked, line_err;
  logic [CNT_W-1:0] pix_x, pix_y, meas_width, meas_height, meas_htotal;
  logic [23:0]      pix_rgb, frame_cksum;
  logic [15:0]      frame_cnt;

  vga_frame_monitor #(.EXP_H_ACTIVE(EXP_H), .EXP_V_ACTIVE(EXP_V), .CNT_W(CNT_W)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .pix_en(pix_en),
    .vga_HS(vga_HS), .vga_VS(vga_VS), .vga_BLANK(vga_BLANK),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .meas_width(meas_width), .meas_height(meas_height),
    .meas_htotal(meas_htotal), .frame_cksum(frame_cksum), .frame_cnt(frame_cnt),
    .locked(locked), .line_err(line_err)
  );

  always #5 clk_clk = ~clk_clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state, kept in terms of frames and lines.
  bit seeking;      // no frame boundary seen since reset
  int m_frame_cnt;
  bit m_locked;
  bit m_line_err;
  int m_prev_len;   // length in samples of the line before the current one
  int m_pend_w;     // width of the previous tracked line, judged when it closes
  int s_w, s_h, s_ck; // statistics of the last fully sent frame

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      pix_en = 1'b0;
      vga_HS = 1'($urandom); vga_VS = 1'($urandom); vga_BLANK = 1'($urandom);
      vga_R = 8'($urandom); vga_G = 8'($urandom); vga_B = 8'($urandom);
      @(posedge clk_clk); #1;
      check_val("idle_pix_valid", {63'd0, pix_valid}, 64'd0);
      check_val("idle_frame_done", {63'd0, frame_done}, 64'd0);
    end
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    pix_en = 1'($urandom);
    vga_HS = 1'($urandom); vga_VS = 1'($urandom); vga_BLANK = 1'($urandom);
    repeat (2) @(posedge clk_clk);
    #1;
    check_val("rst_pix_valid", {63'd0, pix_valid}, 64'd0);
    check_val("rst_pix_xy", {40'd0, pix_x, pix_y}, 64'd0);
    check_val("rst_pix_rgb", {40'd0, pix_rgb}, 64'd0);
    check_val("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check_val("rst_meas", {28'd0, meas_width, meas_height, meas_htotal}, 64'd0);
    check_val("rst_cksum", {40'd0, frame_cksum}, 64'd0);
    check_val("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    check_val("rst_flags", {62'd0, locked, line_err}, 64'd0);
    reset_reset = 1'b0;
    seeking = 1'b1; m_frame_cnt = 0; m_locked = 1'b0; m_line_err = 1'b0;
    m_prev_len = 0; m_pend_w = 0; s_w = 0; s_h = 0; s_ck = 0;
  endtask

  // One frame: HS low for HSYNC samples at line start, VS low for the first
  // VSYNC lines, active lines vstart..vstart+nact-1, active pixels from
  // column hst. Line bad_line (index among active lines) gets width bad_w.
  // rgb_mode: 0 random, 1 constant 0x010203, 2 random except (5,2)=0x102030.
  // tail extends the last line with blank samples; stop_after>=0 aborts.
  task automatic send_frame(input int nact, input int vstart, input int hst,
                            input int bad_line, input int bad_w, input int rgb_mode,
                            input int tail, input int stop_after);
    int ck, last_w, n, w, len, x, y, exp_ht;
    bit act_line, pa, exp_fd;
    logic [23:0] rgb;
    ck = 0; last_w = 0; n = 0;
    for (int l = 0; l < VTOT; l++) begin
      act_line = (l >= vstart) && (l < vstart + nact);
      w = act_line ? (((l - vstart) == bad_line) ? bad_w : EXP_H) : 0;
      len = HTOT + ((l == VTOT - 1) ? tail : 0);
      for (int c = 0; c < len; c++) begin
        if (stop_after >= 0 && n == stop_after) return;
        n++;
        pa = act_line && (c >= hst) && (c < hst + w);
        x = c - hst;
        y = l - vstart;
        if (rgb_mode == 1) rgb = 24'h010203;
        else if (rgb_mode == 2 && x == 5 && y == 2) rgb = 24'h102030;
        else rgb = 24'($urandom);
        pix_en = 1'b1;
        vga_HS = (c < HSYNC) ? 1'b0 : 1'b1;
        vga_VS = (l < VSYNC) ? 1'b0 : 1'b1;
        vga_BLANK = pa;
        vga_R = rgb[23:16]; vga_G = rgb[15:8]; vga_B = rgb[7:0];
        @(posedge clk_clk); #1;
        exp_fd = 1'b0;
        if (c == 0) begin
          if (m_pend_w != 0 && m_pend_w != EXP_H) m_line_err = 1'b1;
          exp_ht = (m_prev_len > CMAX) ? CMAX : m_prev_len;
          check_val("meas_htotal", 64'(meas_htotal), 64'(exp_ht));
          m_prev_len = len;
          if (l == 0) begin
            if (seeking) begin
              seeking = 1'b0;
            end else begin
              exp_fd = 1'b1;
              m_frame_cnt = (m_frame_cnt + 1) % 65536;
              m_locked = (s_w == EXP_H) && (s_h == EXP_V);
              check_val("meas_width", 64'(meas_width), 64'(s_w));
              check_val("meas_height", 64'(meas_height), 64'(s_h));
              check_val("frame_cksum", 64'(frame_cksum), 64'(s_ck));
            end
            check_val("frame_cnt", 64'(frame_cnt), 64'(m_frame_cnt));
          end
          check_val("line_err", {63'd0, line_err}, {63'd0, m_line_err});
          check_val("locked", {63'd0, locked}, {63'd0, m_locked});
        end
        check_val("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
        check_val("pix_valid", {63'd0, pix_valid}, {63'd0, (pa && !seeking)});
        if (pa && !seeking) begin
          check_val("pix_x", 64'(pix_x), 64'(x));
          check_val("pix_y", 64'(pix_y), 64'(y));
          check_val("pix_rgb", 64'(pix_rgb), 64'(rgb));
          ck += int'(rgb[23:16]) + int'(rgb[15:8]) + int'(rgb[7:0]);
        end
        idle_gap();
      end
      m_pend_w = seeking ? 0 : w;
      if (act_line) last_w = w;
    end
    s_w = last_w; s_h = nact; s_ck = ck % (1 << 24);
  endtask

  task automatic good_frame(input int rgb_mode);
    send_frame(EXP_V, 3, 5, -1, 0, rgb_mode, 0, -1);
  endtask

  initial begin
    int nact, vst, hst, bl, bw;
    do_reset();
    // Lock-up: first boundary ignored, second reports a 16x8 frame.
    good_frame(2);
    good_frame(2);
    // Constant colour: 16*8*6 = 768.
    good_frame(1);
    check_val("cksum_const_pending", 64'(s_ck), 64'd768);
    // Short line mid-frame; last active line is the last raster line.
    send_frame(EXP_V, 4, 5, 3, EXP_H - 1, 0, 0, -1);
    good_frame(0);
    // Short frame drops lock, good frame restores it.
    send_frame(EXP_V - 1, 3, 5, -1, 0, 0, 0, -1);
    good_frame(0);
    good_frame(0);
    // Randomised frame shapes, some with active pixels inside HS sync.
    for (int f = 0; f < 5; f++) begin
      nact = $urandom_range(EXP_V - 1, EXP_V + 1);
      vst  = $urandom_range(0, VTOT - nact);
      hst  = $urandom_range(1, HTOT - EXP_H - 2);
      bl   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nact - 1) : -1;
      bw   = $urandom_range(1, EXP_H + 2);
      if (bw == EXP_H) bw = EXP_H - 2;
      send_frame(nact, vst, hst, bl, bw, 0, 0, -1);
    end
    // Very long last line saturates the line total.
    send_frame(EXP_V, 3, 5, -1, 0, 0, 4200, -1);
    good_frame(0);
    // Reset mid-line, then relock from zero.
    send_frame(EXP_V, 3, 5, -1, 0, 0, 0, 5 * HTOT + 10);
    do_reset();
    good_frame(0);
    good_frame(0);
    // Single boundary sample to report the last frame.
    send_frame(EXP_V, 3, 5, -1, 0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
